// File: rtl/dsd_pkg.sv
// Shared definitions for the truth-table self-test engine: FSM encoding and
// the default expected F column of the 3-input lab function.
package dsd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  // F = 1 for {x,y,z} = 2, 3, 4, 6
  localparam logic [7:0] TT_F_DEFAULT = 8'h5C;

endpackage

// File: rtl/tt_result_acc.sv
// Accumulates per-vector verdicts of a sweep: failure mask, failing-vector
// count, lowest failing index and the final pass flag.
module tt_result_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       sample_en,
  input  logic       last,
  input  logic [2:0] index,
  input  logic       mismatch,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pass       <= 1'b0;
      err_count  <= 4'd0;
      fail_mask  <= 8'h00;
      first_fail <= 3'd0;
    end else if (sample_en) begin
      if (mismatch) begin
        fail_mask[index] <= 1'b1;
        err_count        <= err_count + 4'd1;
        if (err_count == 4'd0) first_fail <= index;
      end
      // Verdict for the final vector is folded in here so pass lands with done
      if (last) pass <= (err_count == 4'd0) && !mismatch;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps {x,y,z} = 0..7, holds each vector HOLD cycles, then samples F/Fn
// from the function under test and checks them against EXPECT.
module truth_table_checker
  import dsd_pkg::*;
#(
  parameter int         HOLD   = 4,
  parameter logic [7:0] EXPECT = TT_F_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  input  logic       fn_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail
);

  localparam int              CNT_W     = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

  tt_state_e        state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] hold_cnt;
  logic             idle_like;
  logic             clear;
  logic             sample_en;
  logic             mismatch;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign clear     = start && idle_like;
  assign sample_en = (state == ST_SAMPLE);
  // Fn must be the exact complement of the observed F, independent of EXPECT
  assign mismatch  = (f_in != EXPECT[idx]) || (fn_in != ~f_in);

  assign {x, y, z} = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= 3'd0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          idx      <= 3'd0;
          hold_cnt <= '0;
          if (start) begin
            state <= ST_DRIVE;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (hold_cnt == HOLD_LAST) state <= ST_SAMPLE;
          else                       hold_cnt <= hold_cnt + 1'b1;
        end
        ST_SAMPLE: begin
          if (idx == 3'd7) begin
            state <= ST_DONE;
            idx   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ST_DRIVE;
            idx      <= idx + 3'd1;
            hold_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tt_result_acc u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .sample_en  (sample_en),
    .last       (idx == 3'd7),
    .index      (idx),
    .mismatch   (mismatch),
    .pass       (pass),
    .err_count  (err_count),
    .fail_mask  (fail_mask),
    .first_fail (first_fail)
  );

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: two checkers (HOLD=4 and HOLD=1) driving behavioural models
// of the lab function that can be made correct, F-stuck-at-0, or Fn=F.
module tb_truth_table_checker;

  localparam logic [7:0] LAB_F = 8'h5C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;  // 0 correct, 1 F stuck at 0, 2 Fn equals F

  logic       start_a = 1'b0, f_a, fn_a, x_a, y_a, z_a, busy_a, done_a, pass_a;
  logic [3:0] err_a;
  logic [7:0] mask_a;
  logic [2:0] ff_a;

  logic       start_b = 1'b0, f_b, fn_b, x_b, y_b, z_b, busy_b, done_b, pass_b;
  logic [3:0] err_b;
  logic [7:0] mask_b;
  logic [2:0] ff_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .f_in(f_a), .fn_in(fn_a),
    .x(x_a), .y(y_a), .z(z_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_mask(mask_a), .first_fail(ff_a)
  );

  truth_table_checker #(.HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .f_in(f_b), .fn_in(fn_b),
    .x(x_b), .y(y_b), .z(z_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_mask(mask_b), .first_fail(ff_b)
  );

  function automatic logic [1:0] lab_fn(input int m, input logic [2:0] v);
    logic [7:0] tt;
    logic       f;
    tt = LAB_F;
    f  = tt[v];
    case (m)
      1:       return {1'b0, 1'b1};
      2:       return {f, f};
      default: return {f, ~f};
    endcase
  endfunction

  always_comb begin
    {f_a, fn_a} = lab_fn(mode, {x_a, y_a, z_a});
    {f_b, fn_b} = lab_fn(mode, {x_b, y_b, z_b});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Count edges after the start edge until done is seen, bounded.
  task automatic wait_done_a(output int cycles);
    cycles = 0;
    while (!done_a && cycles < 200) begin
      tick();
      cycles++;
    end
    if (!done_a) check("timeout_a", 32'd0, 32'd1);
  endtask

  task automatic sweep_a(input string tag, input logic [7:0] mask,
                         input logic [3:0] err, input logic [2:0] ff, input logic ps);
    int cyc;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check({tag, "_busy"}, busy_a, 1);
    check({tag, "_xyz0"}, {x_a, y_a, z_a}, 0);
    wait_done_a(cyc);
    check({tag, "_cycles"}, cyc, 40);
    check({tag, "_mask"}, mask_a, mask);
    check({tag, "_err"}, err_a, err);
    check({tag, "_first"}, ff_a, ff);
    check({tag, "_pass"}, pass_a, ps);
    check({tag, "_busy_done"}, busy_a, 0);
    tick();
    check({tag, "_done_pulse"}, done_a, 0);
    check({tag, "_pass_hold"}, pass_a, ps);
  endtask

  initial begin
    int cyc;
    tick(); tick();
    rst = 1'b0;
    check("rst_outputs", {x_a, y_a, z_a, busy_a, done_a, pass_a, err_a, mask_a, ff_a}, 0);

    mode = 0; sweep_a("good", 8'h00, 4'd0, 3'd0, 1'b1);
    mode = 1; sweep_a("f0",   8'h5C, 4'd4, 3'd2, 1'b0);
    mode = 2; sweep_a("fneq", 8'hFF, 4'd8, 3'd0, 1'b0);

    // Reset in the middle of a failing sweep
    mode = 1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (15) tick();
    check("mid_mask_before_rst", mask_a, 8'h04);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_outputs", {x_a, y_a, z_a, busy_a, done_a, pass_a, err_a, mask_a, ff_a}, 0);
    tick();
    check("mid_rst_idle", busy_a, 0);
    mode = 0; sweep_a("after_rst", 8'h00, 4'd0, 3'd0, 1'b1);

    // Start pulses while busy are ignored
    mode = 1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 200) begin
      start_a = (cyc == 5 || cyc == 12 || cyc == 27) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    start_a = 1'b0;
    check("busy_start_cycles", cyc, 40);
    check("busy_start_mask", mask_a, 8'h5C);

    // Start held through DONE restarts immediately with cleared results
    start_a = 1'b1;
    mode = 0;
    tick();
    start_a = 1'b0;
    check("restart_busy", busy_a, 1);
    check("restart_err_clr", err_a, 0);
    check("restart_mask_clr", mask_a, 0);
    check("restart_ff_clr", ff_a, 0);
    wait_done_a(cyc);
    check("restart_cycles", cyc, 40);
    check("restart_pass", pass_a, 1);

    // HOLD=1: vector advances every two cycles, done after 16
    mode = 0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("h1_xyz_c0", {x_b, y_b, z_b}, 0);
    tick();
    check("h1_xyz_c1", {x_b, y_b, z_b}, 0);
    tick();
    check("h1_xyz_c2", {x_b, y_b, z_b}, 1);
    tick(); tick();
    check("h1_xyz_c4", {x_b, y_b, z_b}, 2);
    cyc = 4;
    while (!done_b && cyc < 200) begin
      tick();
      cyc++;
    end
    check("h1_cycles", cyc, 16);
    check("h1_pass", pass_b, 1);
    check("h1_err", err_b, 0);
    check("h1_mask", mask_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
